// File: rtl/prio_arb4.sv
// prio_arb4: four-requester arbiter with held grants, release on done/drop/hold limit.
// Optional rotating priority when PRIO_ARB4_RR_EN is defined; fixed 3>2>1>0 otherwise.
//
//   state      | meaning
//   ST_IDLE    | no owner, arbitrate on any request
//   ST_GRANT   | owner latched in gnt_id, grant driven, hold_cnt running
//   ST_RELEASE | one-cycle gap after a grant, arbitrates exactly like IDLE
module prio_arb4 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic [1:0] state;
    logic [7:0] hold_cnt;
    logic [1:0] winner;
    logic       owner_req;
    logic       hit_lim;
    logic       rel;

`ifdef PRIO_ARB4_RR_EN
    logic [1:0] top_prio;

    // Scan from lowest to highest priority so the highest requester is written last.
    always_comb begin
        logic [1:0] idx;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = top_prio - 2'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end
`else
    always_comb begin
        casez (req)
            4'b1???: winner = 2'd3;
            4'b01??: winner = 2'd2;
            4'b001?: winner = 2'd1;
            default: winner = 2'd0;
        endcase
    end
`endif

    // gnt_id is the latched owner while in GRANT.
    assign owner_req = req[gnt_id];
    assign hit_lim   = (HOLD_LIM != 8'd0) && (hold_cnt == HOLD_LIM);
    assign rel       = done | ~owner_req | hit_lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'b00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= 8'd0;
`ifdef PRIO_ARB4_RR_EN
            top_prio  <= 2'd3;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_GRANT: begin
                    if (rel) begin
                        state     <= ST_RELEASE;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= 8'd0;
                        // only the hold limit can be behind an exit with done low and req still high
                        timeout   <= ~done & owner_req;
`ifdef PRIO_ARB4_RR_EN
                        top_prio  <= gnt_id - 2'd1;
`endif
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    if (|req) begin
                        state     <= ST_GRANT;
                        gnt       <= 4'b0001 << winner;
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arb4.sv
// tb_prio_arb4: drives three prio_arb4 instances (HOLD_MAX 16, 4, 0) with shared stimulus
// and compares each against a behavioural owner/hold model. Honours PRIO_ARB4_RR_EN.
module tb_prio_arb4;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [3:0] req;

    logic [3:0] gnt_o [NDUT];
    logic [1:0] id_o  [NDUT];
    logic       val_o [NDUT];
    logic       to_o  [NDUT];

    always #5 clk = ~clk;

    prio_arb4 #(.HOLD_MAX(16)) u_d16 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_o[0]), .gnt_id(id_o[0]), .gnt_valid(val_o[0]), .timeout(to_o[0])
    );
    prio_arb4 #(.HOLD_MAX(4)) u_d4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_o[1]), .gnt_id(id_o[1]), .gnt_valid(val_o[1]), .timeout(to_o[1])
    );
    prio_arb4 #(.HOLD_MAX(0)) u_d0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_o[2]), .gnt_id(id_o[2]), .gnt_valid(val_o[2]), .timeout(to_o[2])
    );

    int n_chk;
    int n_pass;

    // reference model: owner (-1 = none), last id, hold length, timeout, highest-priority index
    int m_owner [NDUT];
    int m_id    [NDUT];
    int m_held  [NDUT];
    int m_to    [NDUT];
    int m_hi    [NDUT];

    function automatic int hold_max(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_step(input int k);
        int o;
        int idx;
        bit lim;
        bit found;
        if (rst) begin
            m_owner[k] = -1;
            m_id[k]    = 0;
            m_held[k]  = 0;
            m_to[k]    = 0;
            m_hi[k]    = 3;
        end else if (m_owner[k] >= 0) begin
            o   = m_owner[k];
            lim = (hold_max(k) != 0) && (m_held[k] == hold_max(k));
            if (done || !req[o] || lim) begin
                m_to[k]    = (!done && req[o]) ? 1 : 0;
                m_owner[k] = -1;
                m_held[k]  = 0;
`ifdef PRIO_ARB4_RR_EN
                m_hi[k]    = (o + 3) % 4;
`endif
            end else begin
                m_to[k]   = 0;
                m_held[k] = (m_held[k] < 255) ? m_held[k] + 1 : 255;
            end
        end else begin
            m_to[k] = 0;
            found   = 0;
            for (int i = 0; i < 4; i++) begin
                idx = (m_hi[k] - i + 4) % 4;
                if (!found && req[idx]) begin
                    found      = 1;
                    m_owner[k] = idx;
                    m_id[k]    = idx;
                    m_held[k]  = 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k);
        int eg;
        eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
        chk($sformatf("d%0d.gnt", k),       int'(gnt_o[k]), eg);
        chk($sformatf("d%0d.gnt_id", k),    int'(id_o[k]),  m_id[k]);
        chk($sformatf("d%0d.gnt_valid", k), int'(val_o[k]), (m_owner[k] >= 0) ? 1 : 0);
        chk($sformatf("d%0d.timeout", k),   int'(to_o[k]),  m_to[k]);
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_step(k);
        #1;
        for (int k = 0; k < NDUT; k++) check_dut(k);
    endtask

    initial begin
        int seq [5];
        int exp_seq [5];
        int n;
        int hi;
        int low0;
        int to0;

        n_chk  = 0;
        n_pass = 0;
        for (int k = 0; k < NDUT; k++) begin
            m_owner[k] = -1; m_id[k] = 0; m_held[k] = 0; m_to[k] = 0; m_hi[k] = 3;
        end

        // reset held with all requests pending
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        repeat (3) step();
        chk("rst.gnt", int'(gnt_o[0]), 0);
        rst = 1'b0;
        step();
        chk("rst_rel.gnt", int'(gnt_o[0]), 8);
        chk("rst_rel.id",  int'(id_o[0]),  3);

        // priority 2 over 1, owner releases with done and drops its request
        req = 4'b0000;
        step();
        step();
        req = 4'b0110;
        step();
        chk("prio.gnt", int'(gnt_o[0]), 4);
        chk("prio.id",  int'(id_o[0]),  2);
        done = 1'b1; req = 4'b0010;
        step();
        chk("prio.gap", int'(gnt_o[0]), 0);
        done = 1'b0;
        step();
        chk("prio.next_gnt", int'(gnt_o[0]), 2);
        chk("prio.next_id",  int'(id_o[0]),  1);

        // release by request drop
        req = 4'b0000;
        step();
        step();
        req = 4'b0001;
        step();
        chk("drop.gnt", int'(gnt_o[0]), 1);
        req = 4'b0000;
        step();
        chk("drop.gnt_off", int'(gnt_o[0]), 0);
        chk("drop.timeout", int'(to_o[0]),  0);
        step();

        // rotation sequence with done on each grant's first cycle
        rst = 1'b1; req = 4'b1111;
        step();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            step();
            if (val_o[0] && !done) begin
                seq[n] = int'(id_o[0]);
                n++;
                done = 1'b1;
            end else begin
                done = 1'b0;
            end
        end
        done = 1'b0;
        chk("seq.count", n, 5);
`ifdef PRIO_ARB4_RR_EN
        exp_seq = '{3, 2, 1, 0, 3};
`else
        exp_seq = '{3, 3, 3, 3, 3};
`endif
        for (int i = 0; i < 5; i++) chk($sformatf("seq[%0d]", i), seq[i], exp_seq[i]);

        // hold limit 4 on u_d4, no limit on u_d0
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b1000;
        step();
        hi = 0;
        for (int c = 0; c < 20 && val_o[1]; c++) begin
            hi++;
            step();
        end
        chk("hold4.cycles",  hi, 4);
        chk("hold4.timeout", int'(to_o[1]), 1);
        step();
        chk("hold4.regrant", int'(gnt_o[1]), 8);
        low0 = 0;
        to0  = 0;
        repeat (300) begin
            step();
            if (!val_o[2]) low0++;
            if (to_o[2])   to0++;
        end
        chk("hold0.gap",     low0, 0);
        chk("hold0.timeout", to0,  0);

        // reset in the middle of a grant, done on the same edge
        rst = 1'b1; done = 1'b1;
        step();
        chk("midrst.gnt",     int'(gnt_o[2]), 0);
        chk("midrst.valid",   int'(val_o[2]), 0);
        chk("midrst.timeout", int'(to_o[2]),  0);
        rst = 1'b0; done = 1'b0;
        step();
        chk("midrst.resume", int'(gnt_o[2]), 8);

        // random traffic, requests mostly held to let grants persist
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
